// File: rtl/sme_sched_if.sv
// Bundle of requester, buffer-read and SME-core signals for the SME job scheduler.
// The slave modport is the scheduler's view; the master modport is the
// requesters / character buffers / SME core side.
interface sme_sched_if;
  // requester side
  logic [1:0] req;
  logic [5:0] str_len0;
  logic [5:0] str_len1;
  logic [3:0] pat_len0;
  logic [3:0] pat_len1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;
  logic       busy;
  // character buffer read port
  logic       rd_en;
  logic       rd_sel;
  logic       rd_pat;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  // SME core stream and result
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_index;

  modport slave (
    input  req, str_len0, str_len1, pat_len0, pat_len1,
    input  rd_data, sme_valid, sme_match, sme_index,
    output gnt, done, res_match, res_index, res_err, busy,
    output rd_en, rd_sel, rd_pat, rd_addr,
    output chardata, isstring, ispattern
  );

  modport master (
    output req, str_len0, str_len1, pat_len0, pat_len1,
    output rd_data, sme_valid, sme_match, sme_index,
    input  gnt, done, res_match, res_index, res_err, busy,
    input  rd_en, rd_sel, rd_pat, rd_addr,
    input  chardata, isstring, ispattern
  );
endinterface

// File: rtl/sme_sched.sv
// Round-robin job scheduler sharing one string-match engine between two
// requesters: reads string/pattern buffers, streams them to the SME, waits for
// the result under a watchdog and returns match/index/error to the requester.
// Every output is a register so nothing combinational leaks to the pins.
module sme_sched #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic       clk,
  input  logic       reset,
  sme_sched_if.slave sched_io
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_STR   = 3'd2,
    S_PAT   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [5:0]       str_len_q, str_len_d;
  logic [3:0]       pat_len_q, pat_len_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             res_match_q, res_match_d;
  logic [4:0]       res_index_q, res_index_d;
  logic             res_err_q, res_err_d;
  logic [7:0]       chardata_q, chardata_d;
  logic             isstring_q, isstring_d;
  logic             ispattern_q, ispattern_d;
  logic             rd_en_q, rd_en_d;
  logic             rd_sel_q, rd_sel_d;
  logic             rd_pat_q, rd_pat_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             busy_q, busy_d;

  logic pick_s;
  logic len_bad_s;
  logic str_last_s;
  logic pat_last_s;
  logic valid_ok_s;
  logic timeout_s;

  // Job qualifiers: illegal lengths, end of each stream, accepted SME result, watchdog expiry.
  always_comb begin
    len_bad_s  = (str_len_q == 6'd0) || (str_len_q > 6'd32) ||
                 (pat_len_q == 4'd0) || (pat_len_q > 4'd8);
    str_last_s = (cnt_q == (str_len_q - 6'd1));
    pat_last_s = (cnt_q == ({2'b00, pat_len_q} - 6'd1));
    valid_ok_s = sched_io.sme_valid && (wait_cnt_q != {CNT_W{1'b0}});
    timeout_s  = (wait_cnt_q == TIMEOUT_C);
  end

  // Round-robin pick: a lone requester wins, on a tie the one after last_q wins.
  always_comb begin
    case (sched_io.req)
      2'b01:   pick_s = 1'b0;
      2'b10:   pick_s = 1'b1;
      2'b11:   pick_s = ~last_q;
      default: pick_s = last_q;
    endcase
  end

  // State register plus all datapath/output registers; reset aborts any job silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      str_len_q   <= 6'd0;
      pat_len_q   <= 4'd0;
      cnt_q       <= 6'd0;
      wait_cnt_q  <= {CNT_W{1'b0}};
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      res_match_q <= 1'b0;
      res_index_q <= 5'd0;
      res_err_q   <= 1'b0;
      chardata_q  <= 8'd0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_pat_q    <= 1'b0;
      rd_addr_q   <= 5'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      cnt_q       <= cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      res_err_q   <= res_err_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      rd_en_q     <= rd_en_d;
      rd_sel_q    <= rd_sel_d;
      rd_pat_q    <= rd_pat_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic of the job FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sched_io.req != 2'b00) state_d = S_GRANT;
        else                       state_d = S_IDLE;
      end
      S_GRANT: begin
        if (len_bad_s) state_d = S_DONE;
        else           state_d = S_STR;
      end
      S_STR: begin
        if (str_last_s) state_d = S_PAT;
        else            state_d = S_STR;
      end
      S_PAT: begin
        if (pat_last_s) state_d = S_WAIT;
        else            state_d = S_PAT;
      end
      S_WAIT: begin
        if (valid_ok_s || timeout_s) state_d = S_DONE;
        else                         state_d = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; read strobes are registered from the next state
  // so rd_addr in a STR/PAT cycle equals cnt_q and rd_data can be captured directly.
  always_comb begin
    sel_d       = sel_q;
    last_d      = last_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    cnt_d       = cnt_q;
    wait_cnt_d  = wait_cnt_q;
    gnt_d       = gnt_q;
    done_d      = 2'b00;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    res_err_d   = res_err_q;
    chardata_d  = chardata_q;
    isstring_d  = isstring_q;
    ispattern_d = ispattern_q;
    case (state_q)
      S_IDLE: begin
        if (sched_io.req != 2'b00) begin
          sel_d     = pick_s;
          str_len_d = pick_s ? sched_io.str_len1 : sched_io.str_len0;
          pat_len_d = pick_s ? sched_io.pat_len1 : sched_io.pat_len0;
          gnt_d     = pick_s ? 2'b10 : 2'b01;
        end else begin
          gnt_d = 2'b00;
        end
      end
      S_GRANT: begin
        cnt_d = 6'd0;
        if (len_bad_s) begin
          res_err_d   = 1'b1;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
        end else begin
          res_err_d = res_err_q;
        end
      end
      S_STR: begin
        chardata_d  = sched_io.rd_data;
        isstring_d  = 1'b1;
        ispattern_d = 1'b0;
        if (str_last_s) cnt_d = 6'd0;
        else            cnt_d = cnt_q + 6'd1;
      end
      S_PAT: begin
        chardata_d  = sched_io.rd_data;
        isstring_d  = 1'b0;
        ispattern_d = 1'b1;
        if (pat_last_s) begin
          cnt_d      = 6'd0;
          wait_cnt_d = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_WAIT: begin
        chardata_d  = 8'd0;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        wait_cnt_d  = wait_cnt_q + CNT_W'(1);
        if (valid_ok_s) begin
          res_match_d = sched_io.sme_match;
          res_index_d = sched_io.sme_index;
          res_err_d   = 1'b0;
        end else if (timeout_s) begin
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          res_err_d   = 1'b1;
        end else begin
          res_err_d = res_err_q;
        end
      end
      S_DONE: begin
        done_d = gnt_q;
        gnt_d  = 2'b00;
        last_d = sel_q;
      end
      default: begin
        gnt_d = 2'b00;
      end
    endcase

    rd_en_d  = (state_d == S_STR) || (state_d == S_PAT);
    rd_pat_d = (state_d == S_PAT);
    if (rd_en_d) begin
      rd_sel_d  = sel_d;
      rd_addr_d = cnt_d[4:0];
    end else begin
      rd_sel_d  = 1'b0;
      rd_addr_d = 5'd0;
    end
    busy_d = (state_d != S_IDLE);
  end

  assign sched_io.gnt       = gnt_q;
  assign sched_io.done      = done_q;
  assign sched_io.res_match = res_match_q;
  assign sched_io.res_index = res_index_q;
  assign sched_io.res_err   = res_err_q;
  assign sched_io.busy      = busy_q;
  assign sched_io.rd_en     = rd_en_q;
  assign sched_io.rd_sel    = rd_sel_q;
  assign sched_io.rd_pat    = rd_pat_q;
  assign sched_io.rd_addr   = rd_addr_q;
  assign sched_io.chardata  = chardata_q;
  assign sched_io.isstring  = isstring_q;
  assign sched_io.ispattern = ispattern_q;

endmodule

// File: tb/tb_sme_sched.sv
// Directed bench for sme_sched: character buffers, a small SME model with
// reference / never-valid / always-valid behaviours, and hand-computed checks.
module tb_sme_sched;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   sme_mode;   // 0 reference SME, 1 never valid, 2 always valid

  logic [7:0] str_mem [2][32];
  logic [7:0] pat_mem [2][8];

  sme_sched_if bus ();

  sme_sched #(.TIMEOUT(20), .CNT_W(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .sched_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rd_data = bus.rd_pat ? pat_mem[bus.rd_sel][bus.rd_addr[2:0]]
                                  : str_mem[bus.rd_sel][bus.rd_addr];

  // SME model state
  logic [7:0] s_buf [32];
  logic [7:0] p_buf [8];
  int         s_n = 0;
  int         p_n = 0;
  int         pend = 0;
  logic       prev_pat = 1'b0;
  logic       m_calc = 1'b0;
  logic [4:0] i_calc = 5'd0;

  // SME model: collects the stream, answers two cycles after the pattern ends.
  always @(negedge clk) begin
    logic v, mt, eq;
    logic [4:0] ix;
    v = 1'b0; mt = 1'b0; ix = 5'd0;
    if (bus.gnt == 2'b00) begin s_n = 0; p_n = 0; end
    if (bus.isstring && s_n < 32) begin s_buf[s_n] = bus.chardata; s_n++; end
    if (bus.ispattern && p_n < 8) begin p_buf[p_n] = bus.chardata; p_n++; end
    case (sme_mode)
      0: begin
        if (pend == 1) begin v = 1'b1; mt = m_calc; ix = i_calc; end
        if (pend > 0) pend--;
        if (prev_pat && !bus.ispattern) begin
          m_calc = 1'b0; i_calc = 5'd0;
          for (int i = 0; i + p_n <= s_n; i++) begin
            eq = 1'b1;
            for (int k = 0; k < p_n; k++) if (s_buf[i+k] != p_buf[k]) eq = 1'b0;
            if (eq && !m_calc) begin m_calc = 1'b1; i_calc = 5'(i); end
          end
          pend = 2;
        end
      end
      1: v = 1'b0;
      default: begin v = 1'b1; mt = 1'b1; ix = 5'd9; end
    endcase
    prev_pat      = bus.ispattern;
    bus.sme_valid = v;
    bus.sme_match = mt;
    bus.sme_index = ix;
  end

  // Stream and done monitors.
  int         s_tot = 0;
  int         p_tot = 0;
  int         ov_tot = 0;
  int         dg_bad = 0;
  logic [1:0] prev_gnt = 2'b00;
  always @(negedge clk) begin
    if (bus.isstring) s_tot++;
    if (bus.ispattern) p_tot++;
    if (bus.isstring && bus.ispattern) ov_tot++;
    if (bus.done != 2'b00 && bus.done != prev_gnt) dg_bad++;
    prev_gnt = bus.gnt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.gnt, bus.done, bus.busy, bus.rd_en, bus.rd_sel, bus.rd_pat,
                bus.rd_addr, bus.chardata, bus.isstring, bus.ispattern,
                bus.res_match, bus.res_index, bus.res_err});
  endfunction

  task automatic load(input int r, input string s, input string p);
    for (int i = 0; i < s.len(); i++) str_mem[r][i] = s[i];
    for (int i = 0; i < p.len(); i++) pat_mem[r][i] = p[i];
    if (r == 0) begin
      bus.str_len0 = 6'(s.len()); bus.pat_len0 = 4'(p.len());
    end else begin
      bus.str_len1 = 6'(s.len()); bus.pat_len1 = 4'(p.len());
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.done == 2'b00 && cyc < 200);
    if (bus.done == 2'b00) chk("done_seen", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int s0, p0;
    n_checks = 0; n_errors = 0; sme_mode = 0;
    reset = 1'b0;
    bus.req = 2'b00;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) str_mem[r][i] = 8'd0;
      for (int i = 0; i < 8; i++) pat_mem[r][i] = 8'd0;
    end
    load(0, "abcab", "ca");
    load(1, "xyz", "q");
    repeat (3) @(negedge clk);
    chk("rst_outputs", out_vec(), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outputs", out_vec(), 32'd0);

    // round robin with both requesting
    bus.req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_done(cyc);
      chk("rr_done", 32'(bus.done), (j % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_gnt_clr", 32'(bus.gnt), 32'd0);
      chk("rr_res", 32'({bus.res_err, bus.res_match, bus.res_index}),
          (j % 2 == 0) ? 32'h22 : 32'h00);
      if (j == 3) bus.req = 2'b00;
      @(negedge clk);
      chk("rr_pulse", 32'(bus.done), 32'd0);
    end
    repeat (2) @(negedge clk);

    // illegal pattern length on requester 1
    load(1, "xyz", "q");
    bus.pat_len1 = 4'd0;
    s0 = s_tot; p0 = p_tot;
    bus.req = 2'b10;
    wait_done(cyc);
    bus.req = 2'b00;
    chk("bad_latency", 32'(cyc), 32'd3);
    chk("bad_done", 32'(bus.done), 32'd2);
    chk("bad_err", 32'(bus.res_err), 32'd1);
    chk("bad_res", 32'({bus.res_match, bus.res_index}), 32'd0);
    chk("bad_stream", 32'((s_tot - s0) + (p_tot - p0)), 32'd0);
    repeat (2) @(negedge clk);

    // reference match: "wor" in "hello world" at index 6
    load(0, "hello world", "wor");
    s0 = s_tot; p0 = p_tot;
    bus.req = 2'b01;
    wait_done(cyc);
    bus.req = 2'b00;
    chk("hello_latency", 32'(cyc), 32'd21);
    chk("hello_done", 32'(bus.done), 32'd1);
    chk("hello_match", 32'(bus.res_match), 32'd1);
    chk("hello_index", 32'(bus.res_index), 32'd6);
    chk("hello_err", 32'(bus.res_err), 32'd0);
    chk("hello_str_cycles", 32'(s_tot - s0), 32'd11);
    chk("hello_pat_cycles", 32'(p_tot - p0), 32'd3);
    repeat (2) @(negedge clk);

    // watchdog: SME never answers
    sme_mode = 1;
    load(0, "abcd", "xy");
    bus.req = 2'b01;
    wait_done(cyc);
    bus.req = 2'b00;
    chk("to_latency", 32'(cyc), 32'd30);
    chk("to_done", 32'(bus.done), 32'd1);
    chk("to_err", 32'(bus.res_err), 32'd1);
    chk("to_res", 32'({bus.res_match, bus.res_index}), 32'd0);
    repeat (2) @(negedge clk);

    // SME valid held high: first WAIT cycle ignored
    sme_mode = 2;
    load(0, "abc", "bc");
    bus.req = 2'b01;
    wait_done(cyc);
    bus.req = 2'b00;
    chk("cv_latency", 32'(cyc), 32'd10);
    chk("cv_res", 32'({bus.res_err, bus.res_match, bus.res_index}), 32'h29);
    repeat (2) @(negedge clk);
    sme_mode = 0;
    repeat (2) @(negedge clk);

    // reset in the middle of a job, request kept high
    load(0, "hello world", "wor");
    bus.req = 2'b01;
    cyc = 0;
    while (bus.rd_pat == 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mr_reach_pat", 32'(bus.rd_pat), 32'd1);
    #2 reset = 1'b0;
    #1 chk("mr_async_clear", out_vec(), 32'd0);
    @(negedge clk);
    chk("mr_held_clear", out_vec(), 32'd0);
    reset = 1'b1;
    wait_done(cyc);
    bus.req = 2'b00;
    chk("mr_latency", 32'(cyc), 32'd21);
    chk("mr_done", 32'(bus.done), 32'd1);
    chk("mr_res", 32'({bus.res_err, bus.res_match, bus.res_index}), 32'h26);
    repeat (2) @(negedge clk);

    chk("done_vs_gnt", 32'(dg_bad), 32'd0);
    chk("str_pat_overlap", 32'(ov_tot), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
